// File: rtl/sap_sequencer.sv
// Microcoded stage sequencer for the 8-bit CPU: steps T0..T5 and decodes the 15-bit control word.
// Optional stage-by-stage single-step mode is built when SINGLE_STEP_EN is defined.
module sap_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  input  logic [3:0]  opcode,
  output logic [2:0]  stage,
  output logic [14:0] ctrl,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_IDLE = 3'd6,
    ST_HALT = 3'd7
  } stage_e;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd5;
  localparam logic [3:0] OP_STA = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;

  localparam logic [14:0] INACT = 15'h0FE3;

  stage_e      stage_q, stage_d;
  logic [3:0]  op_q, op_d;
  logic        halted_q, halted_d;
  logic        adv_s;
  logic        last_s;
  logic [3:0]  dec_op_s;
  logic [14:0] word_s;

  // Control word asserted by a stage for a given opcode (ignores advance enable).
  function automatic logic [14:0] stage_word(input stage_e s, input logic [3:0] op);
    logic [14:0] w;
    w = INACT;
    case (s)
      ST_T0: w = 15'h27E3;
      ST_T1: w = 15'h4FE3;
      ST_T2: w = 15'h0D63;
      ST_T3: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = 15'h07A3;
          OP_OUT:                         w = 15'h0FF2;
          OP_JMP:                         w = 15'h1FA3;
          default:                        w = INACT;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_LDA:         w = 15'h0DC3;
          OP_ADD, OP_SUB: w = 15'h0DE1;
          OP_STA:         w = 15'h0BF3;
          default:        w = INACT;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_ADD:  w = 15'h0FC7;
          OP_SUB:  w = 15'h0FCF;
          OP_STA:  w = 15'h0EE3;
          default: w = INACT;
        endcase
      end
      default: w = INACT;
    endcase
    return w;
  endfunction

  // True when stage s is the final execute stage of op (HLT never completes).
  function automatic logic is_last(input stage_e s, input logic [3:0] op);
    logic l;
    l = 1'b0;
    case (s)
      ST_T3: begin
        case (op)
          OP_HLT, OP_LDA, OP_ADD, OP_SUB, OP_STA: l = 1'b0;
          default:                                l = 1'b1;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_STA: l = 1'b0;
          default:                l = 1'b1;
        endcase
      end
      ST_T5:   l = 1'b1;
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  // Advance enable, decode selection and next-state logic.
  always_comb begin
`ifdef SINGLE_STEP_EN
    adv_s = run & (~step_mode | step);
`else
    adv_s = run;
`endif
    dec_op_s = (stage_q == ST_T3) ? opcode : op_q;
    word_s   = stage_word(stage_q, dec_op_s);
    last_s   = is_last(stage_q, dec_op_s);
    stage_d  = stage_q;
    op_d     = op_q;
    if (adv_s) begin
      case (stage_q)
        ST_IDLE: stage_d = ST_T0;
        ST_T0:   stage_d = ST_T1;
        ST_T1:   stage_d = ST_T2;
        ST_T2:   stage_d = ST_T3;
        ST_T3: begin
          op_d = opcode;
          if (opcode == OP_HLT) begin
            stage_d = ST_HALT;
          end else if (last_s) begin
            stage_d = ST_T0;
          end else begin
            stage_d = ST_T4;
          end
        end
        ST_T4:   stage_d = last_s ? ST_T0 : ST_T5;
        ST_T5:   stage_d = ST_T0;
        ST_HALT: stage_d = ST_HALT;
        default: stage_d = ST_IDLE;
      endcase
    end else begin
      stage_d = stage_q;
    end
    halted_d = (stage_d == ST_HALT);
  end

  // Sequencer state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q  <= ST_IDLE;
      op_q     <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      op_q     <= op_d;
      halted_q <= halted_d;
    end
  end

  // No partial-stage assertion: a word is driven only in a cycle that advances.
  assign ctrl       = adv_s ? word_s : INACT;
  assign instr_done = adv_s & last_s;
  assign stage      = stage_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed self-checking bench for sap_sequencer: fetch/execute words, hold, halt and reset.
module tb_sap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  opcode;
  logic [2:0]  stage;
  logic [14:0] ctrl;
  logic        instr_done;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step_mode;
  logic        step;
`endif

  int n_checks;
  int n_fail;

  localparam logic [14:0] INACT = 15'h0FE3;

  sap_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
`ifdef SINGLE_STEP_EN
    .step_mode  (step_mode),
    .step       (step),
`endif
    .opcode     (opcode),
    .stage      (stage),
    .ctrl       (ctrl),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st, input logic [14:0] w,
                           input logic done, input logic hlt);
    #1;
    chk({tag, ".stage"}, {13'd0, stage}, {13'd0, st});
    chk({tag, ".ctrl"}, {1'b0, ctrl}, {1'b0, w});
    chk({tag, ".done"}, {15'd0, instr_done}, {15'd0, done});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
  endtask

  // Runs one instruction starting at T0, ending with a check that T0 is reached again.
  task automatic do_instr(input string tag, input logic [3:0] op, input int len,
                          input logic [14:0] w3, input logic [14:0] w4, input logic [14:0] w5);
    opcode = op;
    chk_state({tag, ".T0"}, 3'd0, 15'h27E3, 1'b0, 1'b0);
    tick();
    chk_state({tag, ".T1"}, 3'd1, 15'h4FE3, 1'b0, 1'b0);
    tick();
    chk_state({tag, ".T2"}, 3'd2, 15'h0D63, 1'b0, 1'b0);
    tick();
    chk_state({tag, ".T3"}, 3'd3, w3, (len == 4), 1'b0);
    if (len > 4) begin
      tick();
      chk_state({tag, ".T4"}, 3'd4, w4, (len == 5), 1'b0);
    end
    if (len > 5) begin
      tick();
      chk_state({tag, ".T5"}, 3'd5, w5, 1'b1, 1'b0);
    end
    tick();
    #1;
    chk({tag, ".end"}, {13'd0, stage}, 16'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    opcode   = 4'd0;
`ifdef SINGLE_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif

    // Reset held two cycles.
    tick();
    tick();
    chk_state("reset", 3'd6, INACT, 1'b0, 1'b0);

    // Release with run high: IDLE for one cycle, then T0.
    rst_n  = 1'b1;
    run    = 1'b1;
    opcode = 4'd4;
    chk_state("idle", 3'd6, INACT, 1'b0, 1'b0);
    tick();

    do_instr("lda", 4'd4, 5, 15'h07A3, 15'h0DC3, INACT);
    do_instr("add", 4'd2, 6, 15'h07A3, 15'h0DE1, 15'h0FC7);
    do_instr("sub", 4'd3, 6, 15'h07A3, 15'h0DE1, 15'h0FCF);
    do_instr("sta", 4'd6, 6, 15'h07A3, 15'h0BF3, 15'h0EE3);
    do_instr("out", 4'd5, 4, 15'h0FF2, INACT, INACT);
    do_instr("jmp", 4'd7, 4, 15'h1FA3, INACT, INACT);
    do_instr("nop", 4'd1, 4, INACT, INACT, INACT);
    do_instr("undef", 4'd9, 4, INACT, INACT, INACT);

    // Hold during ADD T4 with the opcode changed; op_q must keep ADD.
    opcode = 4'd2;
    tick();
    tick();
    tick();
    tick();
    chk_state("hold.T4", 3'd4, 15'h0DE1, 1'b0, 1'b0);
    run    = 1'b0;
    opcode = 4'd5;
    chk_state("hold.drop", 3'd4, INACT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("hold.wait", 3'd4, INACT, 1'b0, 1'b0);
    end
    run = 1'b1;
    chk_state("hold.resume", 3'd4, 15'h0DE1, 1'b0, 1'b0);
    tick();
    chk_state("hold.T5", 3'd5, 15'h0FC7, 1'b1, 1'b0);
    tick();
    #1;
    chk("hold.end", {13'd0, stage}, 16'd0);

    // Reset mid-instruction while run is high: reset wins.
    opcode = 4'd2;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_state("midrst", 3'd6, INACT, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("midrst.T0", {13'd0, stage}, 16'd0);

    // HLT: T3 inactive, then HALTED held regardless of opcode.
    opcode = 4'd0;
    tick();
    tick();
    tick();
    chk_state("hlt.T3", 3'd3, INACT, 1'b0, 1'b0);
    tick();
    chk_state("hlt.enter", 3'd7, INACT, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      opcode = (i[0]) ? 4'd2 : 4'd5;
      tick();
      chk_state("hlt.hold", 3'd7, INACT, 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    tick();
    chk_state("hlt.reset", 3'd6, INACT, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("hlt.restart", {13'd0, stage}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
